// File: rtl/psram_qspi_pkg.sv
// Shared definitions for the QSPI PSRAM responder and its controller bench.
// Holds the responder state enum, the supported command opcodes and the
// command/address framing lengths of the QSPI link.
package psram_qspi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_RDATA,
        ST_WDATA,
        ST_IGNORE
    } state_e;

    localparam logic [7:0] CMD_QREAD    = 8'hEB;
    localparam logic [7:0] CMD_QWRITE   = 8'h38;

    // Command is sent one bit per SCK on dio[0]; address is 24 bits as nibbles.
    localparam int         CMD_BITS     = 8;
    localparam int         ADDR_BITS    = 24;
    localparam int         ADDR_NIBBLES = ADDR_BITS / 4;

endpackage

// File: rtl/psram_qspi_responder_edge_sync.sv
// qspi_edge_sync: input register stage and edge detector for the QSPI pins.
// SCK, CE_N and DIO are registered once; SCK and CE_N edges are found by
// comparing the registered value with its previous registered value.
// Ports:
//   clk_i, rst_ni      system clock, async active-low reset
//   sck_i, ce_n_i      raw serial clock and chip enable from the pins
//   dio_i[3:0]         raw resolved data pins
//   dio_sync_o[3:0]    registered data pins, aligned with the edge flags
//   sck_rise_o/fall_o  one-cycle SCK edge flags
//   ce_fall_o/rise_o   one-cycle CE_N edge flags
module qspi_edge_sync (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       sck_i,
    input  logic       ce_n_i,
    input  logic [3:0] dio_i,
    output logic [3:0] dio_sync_o,
    output logic       sck_rise_o,
    output logic       sck_fall_o,
    output logic       ce_fall_o,
    output logic       ce_rise_o
);

    logic       sck_q;
    logic       sck_prev_q;
    logic       ce_n_q;
    logic       ce_n_prev_q;
    logic [3:0] dio_q;

    // CE_N resets to the deasserted level so reset release never looks like a select.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sck_q       <= 1'b0;
            sck_prev_q  <= 1'b0;
            ce_n_q      <= 1'b1;
            ce_n_prev_q <= 1'b1;
            dio_q       <= 4'h0;
        end else begin
            sck_q       <= sck_i;
            sck_prev_q  <= sck_q;
            ce_n_q      <= ce_n_i;
            ce_n_prev_q <= ce_n_q;
            dio_q       <= dio_i;
        end
    end

    assign dio_sync_o = dio_q;
    assign sck_rise_o = sck_q & ~sck_prev_q;
    assign sck_fall_o = ~sck_q & sck_prev_q;
    assign ce_fall_o  = ~ce_n_q & ce_n_prev_q;
    assign ce_rise_o  = ce_n_q & ~ce_n_prev_q;

endmodule

// File: rtl/psram_qspi_responder.sv
// psram_qspi_responder: memory-side end of the PSRAM QSPI link.
// Decodes a serial command, a quad 24-bit address and quad data, and serves
// quad reads (0xEB) and quad writes (0x38) from a byte-wide backing store.
// Ports:
//   clk, resetn               system clock, async active-low reset
//   qspi_sck, qspi_ce_n       serial clock and chip enable from the controller
//   qspi_dio_i/_o/_oe         resolved pins in, responder data out, output enables
//   mem_addr, mem_re, mem_rdata   backing-store read port (data one cycle after strobe)
//   mem_we, mem_wdata         backing-store one-cycle write strobe and data
//   cmd_err                   one-cycle pulse on an unsupported command
module psram_qspi_responder
    import psram_qspi_pkg::*;
#(
    parameter int ADDR_W    = 22,
    parameter int DUMMY_CYC = 6
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              qspi_sck,
    input  logic              qspi_ce_n,
    input  logic [3:0]        qspi_dio_i,
    output logic [3:0]        qspi_dio_o,
    output logic [3:0]        qspi_dio_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    output logic              cmd_err
);

    localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYC - 1);

    logic [3:0] dio_s;
    logic       sck_rise, sck_fall, ce_fall, ce_rise;
    logic [7:0] cmd_byte;

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [19:0]       sh_q, sh_d;
    logic              is_read_q, is_read_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        rd_q, rd_d;
    logic              hi_q, hi_d;
    logic [3:0]        dio_o_q, dio_o_d;
    logic [3:0]        oe_q, oe_d;
    logic              mem_re_q, mem_re_d;
    logic              mem_we_q, mem_we_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              cmd_err_q, cmd_err_d;
    logic              re_dly_q;

    qspi_edge_sync u_sync (
        .clk_i      (clk),
        .rst_ni     (resetn),
        .sck_i      (qspi_sck),
        .ce_n_i     (qspi_ce_n),
        .dio_i      (qspi_dio_i),
        .dio_sync_o (dio_s),
        .sck_rise_o (sck_rise),
        .sck_fall_o (sck_fall),
        .ce_fall_o  (ce_fall),
        .ce_rise_o  (ce_rise)
    );

    assign cmd_byte = {sh_q[6:0], dio_s[0]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        is_read_d = is_read_q;
        addr_d    = addr_q;
        rd_d      = rd_q;
        hi_d      = hi_q;
        dio_o_d   = dio_o_q;
        oe_d      = oe_q;
        mem_re_d  = 1'b0;
        mem_we_d  = 1'b0;
        wdata_d   = wdata_q;
        cmd_err_d = 1'b0;

        // Read data arrives the cycle after the strobe; capture it for the next fall.
        if (re_dly_q) begin
            rd_d = mem_rdata;
        end
        // A write is issued at the current address, so the advance follows the strobe.
        if (mem_we_q) begin
            addr_d = addr_q + ADDR_W'(1);
        end

        if (ce_rise) begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
            hi_d    = 1'b1;
            oe_d    = 4'h0;
            dio_o_d = 4'h0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (ce_fall) begin
                        state_d = ST_CMD;
                        cnt_d   = 8'd0;
                    end
                end
                ST_CMD: begin
                    if (sck_rise) begin
                        sh_d  = {sh_q[18:0], dio_s[0]};
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_q == 8'(CMD_BITS - 1)) begin
                            cnt_d = 8'd0;
                            if (cmd_byte == CMD_QREAD) begin
                                is_read_d = 1'b1;
                                state_d   = ST_ADDR;
                            end else if (cmd_byte == CMD_QWRITE) begin
                                is_read_d = 1'b0;
                                state_d   = ST_ADDR;
                            end else begin
                                cmd_err_d = 1'b1;
                                state_d   = ST_IGNORE;
                            end
                        end
                    end
                end
                ST_ADDR: begin
                    if (sck_rise) begin
                        sh_d  = {sh_q[15:0], dio_s};
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_q == 8'(ADDR_NIBBLES - 1)) begin
                            // Upper address bits beyond the store size are dropped.
                            addr_d = ADDR_W'({sh_q, dio_s});
                            cnt_d  = 8'd0;
                            hi_d   = 1'b1;
                            if (is_read_q) begin
                                mem_re_d = 1'b1;
                                state_d  = (DUMMY_CYC == 0) ? ST_RDATA : ST_DUMMY;
                            end else begin
                                state_d  = ST_WDATA;
                            end
                        end
                    end
                end
                ST_DUMMY: begin
                    if (sck_rise) begin
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_q == DUMMY_LAST) begin
                            cnt_d   = 8'd0;
                            state_d = ST_RDATA;
                        end
                    end
                end
                ST_RDATA: begin
                    if (sck_fall) begin
                        oe_d = 4'hF;
                        if (hi_q) begin
                            dio_o_d = rd_q[7:4];
                            hi_d    = 1'b0;
                        end else begin
                            // Low nibble out: prefetch the following byte.
                            dio_o_d  = rd_q[3:0];
                            hi_d     = 1'b1;
                            addr_d   = addr_q + ADDR_W'(1);
                            mem_re_d = 1'b1;
                        end
                    end
                end
                ST_WDATA: begin
                    if (sck_rise) begin
                        if (hi_q) begin
                            sh_d[3:0] = dio_s;
                            hi_d      = 1'b0;
                        end else begin
                            wdata_d  = {sh_q[3:0], dio_s};
                            mem_we_d = 1'b1;
                            hi_d     = 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 8'd0;
            sh_q      <= 20'd0;
            is_read_q <= 1'b0;
            addr_q    <= '0;
            rd_q      <= 8'd0;
            hi_q      <= 1'b1;
            dio_o_q   <= 4'h0;
            oe_q      <= 4'h0;
            mem_re_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            wdata_q   <= 8'd0;
            cmd_err_q <= 1'b0;
            re_dly_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            is_read_q <= is_read_d;
            addr_q    <= addr_d;
            rd_q      <= rd_d;
            hi_q      <= hi_d;
            dio_o_q   <= dio_o_d;
            oe_q      <= oe_d;
            mem_re_q  <= mem_re_d;
            mem_we_q  <= mem_we_d;
            wdata_q   <= wdata_d;
            cmd_err_q <= cmd_err_d;
            re_dly_q  <= mem_re_q;
        end
    end

    assign qspi_dio_o  = dio_o_q;
    assign qspi_dio_oe = oe_q;
    assign mem_addr    = addr_q;
    assign mem_re      = mem_re_q;
    assign mem_we      = mem_we_q;
    assign mem_wdata   = wdata_q;
    assign cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_psram_qspi_responder.sv
// Bench for psram_qspi_responder: acts as the QSPI controller, provides the
// backing store, and checks every write strobe, every read nibble and the
// output-enable window against a byte-level model of the PSRAM contents.
module tb_psram_qspi_responder;

    localparam int AW    = 22;
    localparam int DUMMY = 6;

    logic          clk = 1'b0;
    logic          resetn;
    logic          qspi_sck;
    logic          qspi_ce_n;
    logic [3:0]    ctrlDio;
    logic [3:0]    dioBus;
    logic [3:0]    dutDio;
    logic [3:0]    dutOe;
    logic [AW-1:0] mem_addr;
    logic          mem_re;
    logic [7:0]    mem_rdata = 8'h00;
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic          cmd_err;

    int   nChecks = 0;
    int   nErrors = 0;
    int   hp = 2;
    logic oeAllowed = 1'b0;
    int   reCount = 0;
    int   weCount = 0;
    int   errCount = 0;

    logic [7:0]  store [0:(1<<AW)-1];
    logic [7:0]  model [int];
    logic [29:0] expWr[$];
    logic [29:0] actWr[$];
    logic [29:0] expHead;
    logic [7:0]  wrBuf[$];
    logic [3:0]  rdNibs[$];

    always #5 clk = ~clk;

    // Pins resolve per bit: the responder wins wherever it enables its driver.
    assign dioBus = (dutOe & dutDio) | (~dutOe & ctrlDio);

    psram_qspi_responder #(.ADDR_W(AW), .DUMMY_CYC(DUMMY)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .qspi_sck    (qspi_sck),
        .qspi_ce_n   (qspi_ce_n),
        .qspi_dio_i  (dioBus),
        .qspi_dio_o  (dutDio),
        .qspi_dio_oe (dutOe),
        .mem_addr    (mem_addr),
        .mem_re      (mem_re),
        .mem_rdata   (mem_rdata),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .cmd_err     (cmd_err)
    );

    // Unwritten locations hold a fixed address-derived pattern.
    function automatic logic [7:0] defByte(input int i);
        return 8'(i) ^ 8'(i >> 9) ^ 8'h5A;
    endfunction

    function automatic logic [7:0] modelRead(input logic [AW-1:0] a);
        return model.exists(int'(a)) ? model[int'(a)] : defByte(int'(a));
    endfunction

    // Backing store: read data is valid the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= store[mem_addr];
        if (mem_we) store[mem_addr] <= mem_wdata;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Every cycle: writes must match the expected queue, strobes stay exclusive,
    // and the responder must not drive the pins outside a read data phase.
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (mem_re) reCount++;
            if (cmd_err) errCount++;
            checkOutput("strobe exclusivity", {31'b0, mem_re & mem_we}, 32'd0);
            if (!oeAllowed) checkOutput("oe outside read data", {28'b0, dutOe}, 32'd0);
            if (mem_we) begin
                weCount++;
                actWr.push_back({mem_addr, mem_wdata});
                if (expWr.size() == 0) begin
                    nChecks++;
                    nErrors++;
                    $display("[TB] FAIL unexpected write: got addr 0x%0h data 0x%0h, required none",
                             mem_addr, mem_wdata);
                end else begin
                    expHead = expWr.pop_front();
                    checkOutput("write addr/data", {2'b0, mem_addr, mem_wdata}, {2'b0, expHead});
                end
            end
        end
    end

    task automatic halfWait();
        repeat (hp) @(negedge clk);
    endtask

    // One SCK period: present v while low, sample the pins at the rise, then fall.
    task automatic clockOut(input logic [3:0] v, output logic [3:0] s);
        ctrlDio = v;
        halfWait();
        s = dioBus;
        qspi_sck = 1'b1;
        halfWait();
        qspi_sck = 1'b0;
    endtask

    task automatic ceLow();
        @(negedge clk);
        qspi_sck  = 1'b0;
        qspi_ce_n = 1'b0;
        halfWait();
    endtask

    task automatic ceHigh();
        halfWait();
        qspi_ce_n = 1'b1;
        repeat (3) @(negedge clk);
        oeAllowed = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic sendCmd(input logic [7:0] b);
        logic [3:0] junk;
        for (int i = 7; i >= 0; i--) clockOut({3'b0, b[i]}, junk);
    endtask

    task automatic sendAddr(input logic [23:0] a);
        logic [3:0] junk;
        for (int n = 5; n >= 0; n--) clockOut(a[n*4 +: 4], junk);
    endtask

    task automatic doWrite(input logic [23:0] a);
        logic [3:0]    junk;
        logic [AW-1:0] ma;
        ceLow();
        sendCmd(8'h38);
        sendAddr(a);
        for (int i = 0; i < wrBuf.size(); i++) begin
            ma = a[AW-1:0] + AW'(i);
            model[int'(ma)] = wrBuf[i];
            expWr.push_back({ma, wrBuf[i]});
            clockOut(wrBuf[i][7:4], junk);
            clockOut(wrBuf[i][3:0], junk);
        end
        ceHigh();
        checkOutput("writes outstanding", 32'(expWr.size()), 32'd0);
    endtask

    task automatic doRead(input logic [23:0] a, input int n);
        logic [3:0]    hiN, loN, junk;
        logic [AW-1:0] ma;
        logic [7:0]    exp;
        rdNibs.delete();
        ceLow();
        sendCmd(8'hEB);
        sendAddr(a);
        repeat (DUMMY) clockOut(4'($urandom), junk);
        oeAllowed = 1'b1;
        for (int i = 0; i < n; i++) begin
            ma  = a[AW-1:0] + AW'(i);
            exp = modelRead(ma);
            clockOut(4'($urandom), hiN);
            checkOutput("oe during read data", {28'b0, dutOe}, 32'hF);
            clockOut(4'($urandom), loN);
            checkOutput("read byte", {24'b0, hiN, loN}, {24'b0, exp});
            rdNibs.push_back(hiN);
            rdNibs.push_back(loN);
        end
        ceHigh();
    endtask

    // One random transaction: bad command, write or read, often near the wrap point.
    task automatic applyStimulus();
        int          kind, n, e0;
        logic [23:0] a;
        logic [7:0]  c;
        logic [3:0]  junk;
        hp   = $urandom_range(2, 3);
        kind = $urandom_range(0, 7);
        n    = $urandom_range(1, 4);
        a[23:22] = 2'($urandom);
        if ($urandom_range(0, 3) == 0) a[21:0] = 22'h3FFFFC + 22'($urandom_range(0, 3));
        else                           a[21:0] = 22'h001000 + 22'($urandom_range(0, 63));
        e0 = errCount;
        if (kind == 0) begin
            c = 8'($urandom);
            if (c == 8'hEB || c == 8'h38) c = 8'h00;
            ceLow();
            sendCmd(c);
            repeat (6) clockOut(4'($urandom), junk);
            ceHigh();
            checkOutput("cmd_err on bad command", 32'(errCount - e0), 32'd1);
        end else begin
            if (kind <= 3) begin
                wrBuf.delete();
                repeat (n) wrBuf.push_back(8'($urandom));
                doWrite(a);
            end else begin
                doRead(a, n);
            end
            checkOutput("no cmd_err on valid command", 32'(errCount - e0), 32'd0);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int         r0, w0, e0;
        logic [3:0] junk;
        for (int i = 0; i < (1 << AW); i++) store[i] = defByte(i);
        store[22'h200] = 8'h12;
        store[22'h201] = 8'h34;
        model[32'h200] = 8'h12;
        model[32'h201] = 8'h34;

        resetn    = 1'b0;
        qspi_sck  = 1'b0;
        qspi_ce_n = 1'b1;
        ctrlDio   = 4'h0;
        repeat (3) @(negedge clk);
        checkOutput("reset dio_o",     {28'b0, dutDio}, 32'd0);
        checkOutput("reset dio_oe",    {28'b0, dutOe}, 32'd0);
        checkOutput("reset mem_re",    {31'b0, mem_re}, 32'd0);
        checkOutput("reset mem_we",    {31'b0, mem_we}, 32'd0);
        checkOutput("reset mem_addr",  {10'b0, mem_addr}, 32'd0);
        checkOutput("reset mem_wdata", {24'b0, mem_wdata}, 32'd0);
        checkOutput("reset cmd_err",   {31'b0, cmd_err}, 32'd0);
        resetn = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] two-byte write at 0x100");
        actWr.delete();
        wrBuf = {8'hA5, 8'h3C};
        doWrite(24'h000100);
        checkOutput("write log size", 32'(actWr.size()), 32'd2);
        checkOutput("first write",  {2'b0, actWr[0]}, {2'b0, 22'h000100, 8'hA5});
        checkOutput("second write", {2'b0, actWr[1]}, {2'b0, 22'h000101, 8'h3C});

        $display("[TB] read of preloaded 0x200");
        doRead(24'h000200, 2);
        checkOutput("nibble 0", {28'b0, rdNibs[0]}, 32'h1);
        checkOutput("nibble 1", {28'b0, rdNibs[1]}, 32'h2);
        checkOutput("nibble 2", {28'b0, rdNibs[2]}, 32'h3);
        checkOutput("nibble 3", {28'b0, rdNibs[3]}, 32'h4);

        $display("[TB] write across the top of the store");
        hp = 3;
        actWr.delete();
        wrBuf = {8'hDE, 8'hAD};
        doWrite(24'h3FFFFF);
        checkOutput("wrap log size", 32'(actWr.size()), 32'd2);
        checkOutput("wrap write 0", {2'b0, actWr[0]}, {2'b0, 22'h3FFFFF, 8'hDE});
        checkOutput("wrap write 1", {2'b0, actWr[1]}, {2'b0, 22'h000000, 8'hAD});
        doRead(24'h3FFFFF, 2);

        $display("[TB] unsupported command 0x9F");
        hp = 2;
        r0 = reCount; w0 = weCount; e0 = errCount;
        ceLow();
        sendCmd(8'h9F);
        repeat (8) clockOut(4'($urandom), junk);
        ceHigh();
        checkOutput("cmd_err pulses", 32'(errCount - e0), 32'd1);
        checkOutput("ignored reads",  32'(reCount - r0), 32'd0);
        checkOutput("ignored writes", 32'(weCount - w0), 32'd0);
        doRead(24'h000200, 2);

        $display("[TB] write aborted after one nibble");
        w0 = weCount;
        ceLow();
        sendCmd(8'h38);
        sendAddr(24'h000300);
        clockOut(4'h7, junk);
        ceHigh();
        checkOutput("partial byte writes", 32'(weCount - w0), 32'd0);
        actWr.delete();
        wrBuf = {8'h99};
        doWrite(24'h000300);
        checkOutput("write after abort", {2'b0, actWr[0]}, {2'b0, 22'h000300, 8'h99});
        doRead(24'h000300, 1);

        $display("[TB] reset during read data");
        ceLow();
        sendCmd(8'hEB);
        sendAddr(24'h000200);
        repeat (DUMMY) clockOut(4'h0, junk);
        oeAllowed = 1'b1;
        clockOut(4'h0, junk);
        clockOut(4'h0, junk);
        @(negedge clk);
        checkOutput("oe before reset", {28'b0, dutOe}, 32'hF);
        resetn = 1'b0;
        #1;
        checkOutput("oe in reset",   {28'b0, dutOe}, 32'd0);
        checkOutput("dio_o in reset", {28'b0, dutDio}, 32'd0);
        checkOutput("mem_re in reset", {31'b0, mem_re}, 32'd0);
        qspi_ce_n = 1'b1;
        repeat (3) @(negedge clk);
        oeAllowed = 1'b0;
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        doRead(24'h000200, 2);
        checkOutput("post-reset nibble 0", {28'b0, rdNibs[0]}, 32'h1);
        checkOutput("post-reset nibble 3", {28'b0, rdNibs[3]}, 32'h4);

        $display("[TB] random transactions");
        for (int t = 0; t < 40; t++) applyStimulus();

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
